// File: rtl/rtx_fb_writer_pkg.sv
// rtx_fb_writer_pkg: shared framebuffer entry type and RGB565 field layout.
package rtx_fb_writer_pkg;
    // Entry address is sized for the widest frame this writer supports (1280x720).
    localparam int FB_ADDR_W = 20;
    localparam int PIX_W     = 16;
    localparam int B_MSB = 15, B_LSB = 11;
    localparam int G_MSB = 10, G_LSB = 5;
    localparam int R_MSB = 4,  R_LSB = 0;

    typedef struct packed {
        logic [FB_ADDR_W-1:0] addr;
        logic [PIX_W-1:0]     data;
    } fb_entry;

    function automatic logic [PIX_W-1:0] rgb565(input logic [4:0] b, input logic [5:0] g, input logic [4:0] r);
        return {b, g, r};
    endfunction
endpackage

// File: rtl/rtx_fb_writer_if.sv
// rtx_fb_writer_if: valid/ready write bus from the writer to the framebuffer.
interface rtx_fb_writer_if #(parameter int ADDR_W = 20);
    logic [ADDR_W-1:0] wr_addr;
    logic [15:0]       wr_data;
    logic              wr_valid;
    logic              wr_ready;

    modport master (output wr_addr, wr_data, wr_valid, input wr_ready);
    modport slave  (input wr_addr, wr_data, wr_valid, output wr_ready);
endinterface

// File: rtl/rtx_fb_writer_pixel_fifo.sv
// pixel_fifo: first-word-fall-through circular queue with occupancy counter.
module pixel_fifo #(
    parameter int W     = 36,
    parameter int DEPTH = 8,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = PW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  din,
    output logic [W-1:0]  dout,
    output logic [CW-1:0] count
);
    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
    end

    // Storage is not reset, so an empty queue presents zeros instead of stale words.
    assign dout = (count != '0) ? mem[rd_ptr] : '0;
endmodule

// File: rtl/rtx_fb_writer.sv
// rtx_fb_writer: tags ray-traced pixels with raster addresses and queues them
// toward the framebuffer, dropping (and flagging) pixels when the queue is full.
module rtx_fb_writer
    import rtx_fb_writer_pkg::*;
#(
    parameter int WIDTH      = 1280,
    parameter int HEIGHT     = 720,
    parameter int FIFO_DEPTH = 8,
    localparam int ADDR_W    = $clog2(WIDTH * HEIGHT),
    localparam int CW        = $clog2(FIFO_DEPTH) + 1,
    localparam int HW        = $clog2(WIDTH + 1),
    localparam int VW        = $clog2(HEIGHT + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [15:0]           rtx_pixel,
    input  logic                  ray_done,
    input  logic                  frame_start,
    rtx_fb_writer_if.master       wr,
    output logic                  frame_done,
    output logic                  overflow,
    output logic [CW-1:0]         fifo_count
);
    logic [HW-1:0]     h, h0, h_nx;
    logic [VW-1:0]     v, v0, v_nx;
    logic [ADDR_W-1:0] addr, a0, a_nx;
    logic              h_end, last, pop, full, push, drop;
    fb_entry           entry_in, head;

    // frame_start re-aligns before tagging, so a coincident pixel lands at (0,0).
    always_comb begin
        h0    = frame_start ? '0 : h;
        v0    = frame_start ? '0 : v;
        a0    = frame_start ? '0 : addr;
        h_end = h0 == HW'(WIDTH - 1);
        last  = h_end && v0 == VW'(HEIGHT - 1);
        h_nx  = h_end ? '0 : h0 + 1'b1;
        v_nx  = last ? '0 : h_end ? v0 + 1'b1 : v0;
        a_nx  = last ? '0 : a0 + 1'b1;
        pop   = wr.wr_valid && wr.wr_ready;
        full  = fifo_count == CW'(FIFO_DEPTH);
        push  = ray_done && (!full || pop);
        drop  = ray_done && !push;
        entry_in = '{addr: FB_ADDR_W'(a0), data: rtx_pixel};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h          <= '0;
            v          <= '0;
            addr       <= '0;
            frame_done <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            h          <= ray_done ? h_nx : h0;
            v          <= ray_done ? v_nx : v0;
            addr       <= ray_done ? a_nx : a0;
            frame_done <= ray_done && last;
            overflow   <= drop || (overflow && !frame_start);
        end
    end

    pixel_fifo #(.W($bits(fb_entry)), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk  (clk),
        .rst  (rst),
        .push (push),
        .pop  (pop),
        .din  (entry_in),
        .dout (head),
        .count(fifo_count)
    );

    assign wr.wr_addr  = ADDR_W'(head.addr);
    assign wr.wr_data  = head.data;
    assign wr.wr_valid = fifo_count != '0;
endmodule
